alu_seq_ctrl: RTL and testbench
===============================

Name: alu_seq_ctrl

Overview:
- Command sequencer for the shared `alu` datapath.
- Holds a small operand register file and accepts one command at a time over a valid/ready handshake. Each command reads two source registers, drives the ALU operand, control and flag-in lines, captures result and flag, writes the result back, and returns a response over a second valid/ready handshake.
- Sits between the host/test controller and the combinational `alu` instance.

Parameters:
- ancho, 4, datapath width; must match the connected alu.
- NREG, 4, number of operand registers; power of two, ≥2.

Ports:
- clk  in  1  system clock, rising edge.
- rst_n  in  1  synchronous active-low reset.
- cmd_valid  in  1  command present.
- cmd_ready  out  1  controller can accept a command.
- cmd_op  in  4  ALU operation code (0x0–0x9 legal).
- cmd_srca  in  log2(NREG)  register index for A.
- cmd_srcb  in  log2(NREG)  register index for B.
- cmd_dst  in  log2(NREG)  destination register index.
- cmd_flagin  in  1  value presented on the ALU flag-in.
- wr_en  in  1  host register write strobe.
- wr_addr  in  log2(NREG)  host write index.
- wr_data  in  ancho  host write data.
- rd_addr  in  log2(NREG)  host read index.
- rd_data  out  ancho  combinational read of reg[rd_addr].
- alu_a  out  ancho  ALU operand A, registered.
- alu_b  out  ancho  ALU operand B, registered.
- alu_ctrl  out  4  ALU control code, registered.
- alu_flagin  out  1  ALU flag-in, registered.
- alu_result  in  ancho  ALU result.
- alu_flags  in  1  ALU carry/shift-out flag.
- rsp_valid  out  1  response present.
- rsp_ready  in  1  consumer accepts response.
- rsp_result  out  ancho  captured result.
- rsp_flag  out  1  captured flag.
- rsp_err  out  1  illegal opcode.
- busy  out  1  state != IDLE.

Behaviour:
- Reset (rst_n=0 at a clk edge):
  - State = IDLE.
  - All registers, alu_a, alu_b, alu_ctrl, alu_flagin, rsp_result, rsp_flag, rsp_err = 0.
  - rsp_valid = 0, busy = 0, cmd_ready = 1 once reset is released.
  - Reset mid-operation aborts the command: no writeback, no response.
- States are IDLE, ISSUE, CAPTURE, RESP.
  - IDLE: cmd_ready=1. On cmd_valid&&cmd_ready, latch op/dst/flagin and go to ISSUE.
    - Legal op: load alu_a=reg[srca], alu_b=reg[srcb], alu_ctrl=op, alu_flagin=flagin.
    - op≥0xA: alu_ctrl=0 and an internal err bit is set.
  - ISSUE: one cycle with the ALU inputs stable; go to CAPTURE.
  - CAPTURE: sample alu_result into rsp_result.
    - Flag rule: rsp_flag = alu_flags for op ∈ {0x2, 0x6, 0x8, 0x9}, else 0. A flag that is x/unused is never forwarded.
    - If not err: reg[dst] ← alu_result.
    - If err: rsp_result=0, rsp_flag=0, rsp_err=1, no writeback.
    - Go to RESP.
  - RESP: rsp_valid=1, holding outputs stable until rsp_ready=1, then go to IDLE.
- cmd_ready=0 in ISSUE, CAPTURE and RESP; there are no back-to-back commands.
- Minimum command-accept to rsp_valid latency is 3 clocks. Minimum throughput is one command per 4 clocks with rsp_ready held high.
- alu_* outputs keep their last value outside ISSUE/CAPTURE.
- Host writes:
  - Accepted in any state.
  - Same cycle and same address as the CAPTURE writeback: the writeback wins and the host write is dropped.
  - Host write to srca/srcb during ISSUE does not affect the in-flight operands, because operands are latched at accept.
- rd_data reflects register contents, including a writeback on the following cycle.
- Width rules:
  - No internal arithmetic; results are taken verbatim at ancho bits.
  - Register indices wrap naturally modulo NREG.
- srca == srcb == dst is legal; the operands are the old value.

Decomposition:
- Package alu_seq_pkg holds:
  - opcode localparams: OP_AND=0, OP_OR=1, OP_ADD=2, OP_INC=3, OP_DEC=4, OP_NOT=5, OP_SUB=6, OP_XOR=7, OP_SHL=8, OP_SHR=9;
  - OP_MAX=9;
  - state encoding constants;
  - a function returning 1 for flag-producing opcodes.
- One sub-module, alu_seq_regfile: NREG×ancho registers, two latched read ports plus an async host read port, and a write port with writeback-over-host priority.
- The FSM lives in the top module.

Test Plan:
- Reset then host-write reg0=0x9, reg1=0x8; cmd op=0x2, srca=0, srcb=1, dst=2 → rsp_valid 3 clocks after accept, rsp_result=0x1, rsp_flag=1, rd_addr=2 reads 0x1.
- reg0=0x5, reg1=0x3; op=0x7 (XOR), dst=3 → rsp_result=0x6, rsp_flag=0, reg3=0x6; op=0x0 → result 0x1.
- op=0xC → rsp_err=1, rsp_result=0, no register changes, next cmd accepted normally.
- Hold rsp_ready=0 for 5 cycles in RESP → outputs stable, cmd_ready=0, second cmd_valid ignored until handshake completes.
- Host write to dst in the same cycle as CAPTURE with wr_data=0xF, ALU result 0x2 → reg[dst]=0x2.
- Assert rst_n=0 during CAPTURE → no writeback, rsp_valid=0, all outputs 0 next cycle, busy=0.

Source files
------------

// File: rtl/alu_seq_pkg.sv
// alu_seq_pkg: shared definitions for the ALU command sequencer.
//   - opcode constants of the attached alu and the highest legal opcode
//   - sequencer state encoding
//   - is_flag_op(): 1 for opcodes whose alu flag output carries meaning
package alu_seq_pkg;

   localparam logic [3:0] OP_AND = 4'h0;
   localparam logic [3:0] OP_OR  = 4'h1;
   localparam logic [3:0] OP_ADD = 4'h2;
   localparam logic [3:0] OP_INC = 4'h3;
   localparam logic [3:0] OP_DEC = 4'h4;
   localparam logic [3:0] OP_NOT = 4'h5;
   localparam logic [3:0] OP_SUB = 4'h6;
   localparam logic [3:0] OP_XOR = 4'h7;
   localparam logic [3:0] OP_SHL = 4'h8;
   localparam logic [3:0] OP_SHR = 4'h9;
   localparam logic [3:0] OP_MAX = OP_SHR;

   typedef enum logic [1:0] {
      ST_IDLE    = 2'd0,
      ST_ISSUE   = 2'd1,
      ST_CAPTURE = 2'd2,
      ST_RESP    = 2'd3
   } state_t;

   // Carry/borrow for ADD/SUB, shifted-out bit for SHL/SHR.
   function automatic logic is_flag_op(input logic [3:0] op);
      return (op == OP_ADD) || (op == OP_SUB) || (op == OP_SHL) || (op == OP_SHR);
   endfunction

endpackage

// File: rtl/alu_seq_regfile.sv
// alu_seq_regfile: NREG x ancho operand registers.
//   clk, rst_n            clock, synchronous active-low reset (clears all)
//   ld, addr_a, addr_b    latch reg[addr_a]/reg[addr_b] into data_a/data_b
//   data_a, data_b        latched operands (drive the alu directly)
//   wb_en/addr/data       sequencer writeback port (highest priority)
//   wr_en/addr/data       host write port, dropped on a same-address writeback
//   rd_addr, rd_data      asynchronous host read
module alu_seq_regfile
   import alu_seq_pkg::*;
#(
   parameter int ancho = 4,
   parameter int NREG  = 4,
   localparam int AW   = $clog2(NREG)
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             ld,
   input  logic [AW-1:0]    addr_a,
   input  logic [AW-1:0]    addr_b,
   output logic [ancho-1:0] data_a,
   output logic [ancho-1:0] data_b,
   input  logic             wb_en,
   input  logic [AW-1:0]    wb_addr,
   input  logic [ancho-1:0] wb_data,
   input  logic             wr_en,
   input  logic [AW-1:0]    wr_addr,
   input  logic [ancho-1:0] wr_data,
   input  logic [AW-1:0]    rd_addr,
   output logic [ancho-1:0] rd_data
);

   logic [ancho-1:0] regs [NREG];

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         regs   <= '{default: '0};
         data_a <= '0;
         data_b <= '0;
      end else begin
         for (int i = 0; i < NREG; i++) begin
            if (wb_en && (wb_addr == AW'(i)))
               regs[i] <= wb_data;
            else if (wr_en && (wr_addr == AW'(i)))
               regs[i] <= wr_data;
         end
         // Operands are the pre-writeback values, so srca==srcb==dst is safe.
         if (ld) begin
            data_a <= regs[addr_a];
            data_b <= regs[addr_b];
         end
      end
   end

   assign rd_data = regs[rd_addr];

endmodule

// File: rtl/alu_seq_ctrl.sv
// alu_seq_ctrl: one-command-at-a-time sequencer for the combinational alu.
//   clk, rst_n                  clock, synchronous active-low reset
//   cmd_*                       command handshake and fields (op, srca, srcb, dst, flagin)
//   wr_*, rd_*                  host register write / async read
//   alu_a/b/ctrl/flagin         registered alu inputs
//   alu_result, alu_flags       alu outputs
//   rsp_*                       response handshake with result, flag, illegal-op error
//   busy                        sequencer not idle
//
// state      | meaning
// -----------+-----------------------------------------------
// ST_IDLE    | ready for a command; operands latched on accept
// ST_ISSUE   | alu inputs settle for one cycle
// ST_CAPTURE | result/flag captured, writeback to dst
// ST_RESP    | rsp_valid held until rsp_ready
module alu_seq_ctrl
   import alu_seq_pkg::*;
#(
   parameter int ancho = 4,
   parameter int NREG  = 4,
   localparam int AW   = $clog2(NREG)
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             cmd_valid,
   output logic             cmd_ready,
   input  logic [3:0]       cmd_op,
   input  logic [AW-1:0]    cmd_srca,
   input  logic [AW-1:0]    cmd_srcb,
   input  logic [AW-1:0]    cmd_dst,
   input  logic             cmd_flagin,
   input  logic             wr_en,
   input  logic [AW-1:0]    wr_addr,
   input  logic [ancho-1:0] wr_data,
   input  logic [AW-1:0]    rd_addr,
   output logic [ancho-1:0] rd_data,
   output logic [ancho-1:0] alu_a,
   output logic [ancho-1:0] alu_b,
   output logic [3:0]       alu_ctrl,
   output logic             alu_flagin,
   input  logic [ancho-1:0] alu_result,
   input  logic             alu_flags,
   output logic             rsp_valid,
   input  logic             rsp_ready,
   output logic [ancho-1:0] rsp_result,
   output logic             rsp_flag,
   output logic             rsp_err,
   output logic             busy
);

   state_t          state, state_nxt;
   logic            accept;
   logic            capture;
   logic            op_legal;
   logic [AW-1:0]   dst_q;
   logic            err_q;

   assign op_legal = (cmd_op <= OP_MAX);

   always_ff @(posedge clk) begin
      if (!rst_n) state <= ST_IDLE;
      else        state <= state_nxt;
   end

   always_comb begin
      state_nxt = state;
      cmd_ready = 1'b0;
      rsp_valid = 1'b0;
      accept    = 1'b0;
      capture   = 1'b0;
      case (state)
         ST_IDLE: begin
            cmd_ready = 1'b1;
            if (cmd_valid) begin
               accept    = 1'b1;
               state_nxt = ST_ISSUE;
            end
         end
         ST_ISSUE:   state_nxt = ST_CAPTURE;
         ST_CAPTURE: begin
            capture   = 1'b1;
            state_nxt = ST_RESP;
         end
         ST_RESP: begin
            rsp_valid = 1'b1;
            if (rsp_ready) state_nxt = ST_IDLE;
         end
         default:    state_nxt = ST_IDLE;
      endcase
   end

   assign busy = (state != ST_IDLE);

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         alu_ctrl   <= '0;
         alu_flagin <= 1'b0;
         dst_q      <= '0;
         err_q      <= 1'b0;
         rsp_result <= '0;
         rsp_flag   <= 1'b0;
         rsp_err    <= 1'b0;
      end else begin
         if (accept) begin
            dst_q <= cmd_dst;
            if (op_legal) begin
               alu_ctrl   <= cmd_op;
               alu_flagin <= cmd_flagin;
               err_q      <= 1'b0;
            end else begin
               alu_ctrl <= OP_AND;
               err_q    <= 1'b1;
            end
         end
         if (capture) begin
            if (err_q) begin
               rsp_result <= '0;
               rsp_flag   <= 1'b0;
               rsp_err    <= 1'b1;
            end else begin
               rsp_result <= alu_result;
               // Flag of non-flag ops may be x/garbage; never let it through.
               rsp_flag   <= is_flag_op(alu_ctrl) && alu_flags;
               rsp_err    <= 1'b0;
            end
         end
      end
   end

   alu_seq_regfile #(.ancho(ancho), .NREG(NREG)) u_regfile (
      .clk     (clk),
      .rst_n   (rst_n),
      .ld      (accept && op_legal),
      .addr_a  (cmd_srca),
      .addr_b  (cmd_srcb),
      .data_a  (alu_a),
      .data_b  (alu_b),
      .wb_en   (capture && !err_q),
      .wb_addr (dst_q),
      .wb_data (alu_result),
      .wr_en   (wr_en),
      .wr_addr (wr_addr),
      .wr_data (wr_data),
      .rd_addr (rd_addr),
      .rd_data (rd_data)
   );

endmodule

// File: tb/tb_alu_seq_ctrl.sv
// tb_alu_seq_ctrl: directed bench for alu_seq_ctrl with a behavioural alu,
// a register model and a response scoreboard queue.
module tb_alu_seq_ctrl;

   localparam int W = 4;
   localparam int N = 4;

   logic         clk = 1'b0;
   logic         rst_n;
   logic         cmd_valid, cmd_ready, cmd_flagin;
   logic [3:0]   cmd_op;
   logic [1:0]   cmd_srca, cmd_srcb, cmd_dst;
   logic         wr_en;
   logic [1:0]   wr_addr, rd_addr;
   logic [W-1:0] wr_data, rd_data;
   logic [W-1:0] alu_a, alu_b, alu_result;
   logic [3:0]   alu_ctrl;
   logic         alu_flagin, alu_flags;
   logic         rsp_valid, rsp_ready, rsp_flag, rsp_err, busy;
   logic [W-1:0] rsp_result;

   typedef struct {
      logic [3:0] res;
      logic       flag;
      logic       err;
   } exp_t;

   exp_t         sb[$];
   logic [W-1:0] refm [N];
   int           n_checks = 0;
   int           n_fail   = 0;

   always #5 clk = ~clk;

   alu_seq_ctrl #(.ancho(W), .NREG(N)) dut (
      .clk(clk), .rst_n(rst_n),
      .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_op(cmd_op),
      .cmd_srca(cmd_srca), .cmd_srcb(cmd_srcb), .cmd_dst(cmd_dst), .cmd_flagin(cmd_flagin),
      .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
      .rd_addr(rd_addr), .rd_data(rd_data),
      .alu_a(alu_a), .alu_b(alu_b), .alu_ctrl(alu_ctrl), .alu_flagin(alu_flagin),
      .alu_result(alu_result), .alu_flags(alu_flags),
      .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_result(rsp_result),
      .rsp_flag(rsp_flag), .rsp_err(rsp_err), .busy(busy)
   );

   // Behavioural alu; flag of non-flag ops is driven high so a leak shows up.
   logic [4:0] wide;
   always_comb begin
      alu_result = '0;
      alu_flags  = 1'b1;
      wide       = '0;
      case (alu_ctrl)
         4'h0: alu_result = alu_a & alu_b;
         4'h1: alu_result = alu_a | alu_b;
         4'h2: begin
            wide = {1'b0, alu_a} + {1'b0, alu_b};
            alu_result = wide[3:0];
            alu_flags  = wide[4];
         end
         4'h3: alu_result = alu_a + 4'd1;
         4'h4: alu_result = alu_a - 4'd1;
         4'h5: alu_result = ~alu_a;
         4'h6: begin
            wide = {1'b0, alu_a} - {1'b0, alu_b};
            alu_result = wide[3:0];
            alu_flags  = wide[4];
         end
         4'h7: alu_result = alu_a ^ alu_b;
         4'h8: begin
            alu_result = {alu_a[2:0], 1'b0};
            alu_flags  = alu_a[3];
         end
         4'h9: begin
            alu_result = {1'b0, alu_a[3:1]};
            alu_flags  = alu_a[0];
         end
         default: alu_result = '0;
      endcase
   end

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_checks++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic host_write(input logic [1:0] a, input logic [W-1:0] d);
      @(negedge clk);
      wr_en = 1'b1; wr_addr = a; wr_data = d;
      @(negedge clk);
      wr_en = 1'b0;
      refm[a] = d;
   endtask

   task automatic check_regs(input string tag);
      for (int i = 0; i < N; i++) begin
         rd_addr = 2'(i);
         #1;
         check(tag, rd_data, refm[i]);
      end
   endtask

   // mode 0: normal, 1: host write 0xF to dst during CAPTURE, 2: reset during CAPTURE
   task automatic run_cmd(input logic [3:0] op, input logic [1:0] a, input logic [1:0] b,
                          input logic [1:0] d, input logic fi,
                          input logic [3:0] er, input logic ef, input logic ee,
                          input int stall, input int mode);
      exp_t e;
      int   k;
      logic [W-1:0] opa, opb;
      opa = refm[a];
      opb = refm[b];
      if (mode != 2) sb.push_back('{er, ef, ee});
      @(negedge clk);
      cmd_valid = 1'b1; cmd_op = op; cmd_srca = a; cmd_srcb = b; cmd_dst = d; cmd_flagin = fi;
      k = 0;
      while (!cmd_ready && k < 20) begin
         @(negedge clk);
         k++;
      end
      check("cmd_ready_idle", cmd_ready, 1);
      @(posedge clk);
      #1;
      cmd_valid = 1'b0;
      for (k = 1; k <= 10; k++) begin
         @(negedge clk);
         if (k == 1) begin
            check("busy_issue", busy, 1);
            check("cmd_ready_issue", cmd_ready, 0);
            check("alu_ctrl", alu_ctrl, ee ? 4'h0 : op);
            if (!ee) begin
               check("alu_a", alu_a, opa);
               check("alu_b", alu_b, opb);
               check("alu_flagin", alu_flagin, fi);
            end
         end
         if (k == 2 && mode == 1) begin
            wr_en = 1'b1; wr_addr = d; wr_data = 4'hF;
         end
         if (k == 2 && mode == 2) begin
            rst_n = 1'b0;
            @(negedge clk);
            rst_n = 1'b1;
            check("rst_rsp_valid", rsp_valid, 0);
            check("rst_busy", busy, 0);
            check("rst_alu_a", alu_a, 0);
            check("rst_alu_b", alu_b, 0);
            check("rst_alu_ctrl", alu_ctrl, 0);
            check("rst_rsp_result", rsp_result, 0);
            for (int i = 0; i < N; i++) refm[i] = '0;
            check_regs("rst_regs");
            return;
         end
         if (rsp_valid) break;
      end
      wr_en = 1'b0;
      check("rsp_latency", k, 3);
      if (sb.size() == 0) begin
         check("sb_nonempty", 0, 1);
         e = '{4'h0, 1'b0, 1'b0};
      end else begin
         e = sb.pop_front();
      end
      check("rsp_result", rsp_result, e.res);
      check("rsp_flag", rsp_flag, e.flag);
      check("rsp_err", rsp_err, e.err);
      for (int i = 0; i < stall; i++) begin
         cmd_valid = 1'b1; cmd_op = 4'h1; cmd_srca = 2'd0; cmd_srcb = 2'd0; cmd_dst = 2'd0;
         @(negedge clk);
         check("stall_valid", rsp_valid, 1);
         check("stall_cmd_ready", cmd_ready, 0);
         check("stall_result", rsp_result, e.res);
         check("stall_flag", rsp_flag, e.flag);
      end
      cmd_valid = 1'b0;
      rsp_ready = 1'b1;
      @(posedge clk);
      #1;
      rsp_ready = 1'b0;
      @(negedge clk);
      check("post_rsp_valid", rsp_valid, 0);
      check("post_cmd_ready", cmd_ready, 1);
      if (!ee) refm[d] = er;
      rd_addr = d;
      #1;
      check("rd_dst", rd_data, refm[d]);
   endtask

   initial begin
      rst_n = 1'b0;
      cmd_valid = 1'b0; cmd_op = '0; cmd_srca = '0; cmd_srcb = '0; cmd_dst = '0; cmd_flagin = 1'b0;
      wr_en = 1'b0; wr_addr = '0; wr_data = '0; rd_addr = '0; rsp_ready = 1'b0;
      for (int i = 0; i < N; i++) refm[i] = '0;
      repeat (3) @(posedge clk);
      @(negedge clk);
      check("reset_rsp_valid", rsp_valid, 0);
      check("reset_busy", busy, 0);
      check("reset_alu_ctrl", alu_ctrl, 0);
      check("reset_alu_a", alu_a, 0);
      check("reset_rsp_result", rsp_result, 0);
      check("reset_rsp_err", rsp_err, 0);
      check_regs("reset_regs");
      rst_n = 1'b1;
      @(negedge clk);
      check("reset_cmd_ready", cmd_ready, 1);

      host_write(2'd0, 4'h9);
      host_write(2'd1, 4'h8);
      run_cmd(4'h2, 2'd0, 2'd1, 2'd2, 1'b0, 4'h1, 1'b1, 1'b0, 0, 0);   // 9+8 = 0x11

      host_write(2'd0, 4'h5);
      host_write(2'd1, 4'h3);
      run_cmd(4'h7, 2'd0, 2'd1, 2'd3, 1'b0, 4'h6, 1'b0, 1'b0, 0, 0);   // 5^3
      run_cmd(4'h0, 2'd0, 2'd1, 2'd2, 1'b0, 4'h1, 1'b0, 1'b0, 0, 0);   // 5&3
      run_cmd(4'h3, 2'd0, 2'd0, 2'd1, 1'b0, 4'h6, 1'b0, 1'b0, 0, 0);   // inc, flag unused

      run_cmd(4'hC, 2'd0, 2'd1, 2'd0, 1'b0, 4'h0, 1'b0, 1'b1, 0, 0);   // illegal
      check_regs("illegal_regs");
      run_cmd(4'h9, 2'd0, 2'd0, 2'd3, 1'b0, 4'h2, 1'b1, 1'b0, 0, 0);   // 0101>>1, out 1

      run_cmd(4'h6, 2'd0, 2'd1, 2'd2, 1'b0, 4'hF, 1'b1, 1'b0, 5, 0);   // 5-6 with stall

      run_cmd(4'h1, 2'd3, 2'd3, 2'd0, 1'b0, 4'h2, 1'b0, 1'b0, 0, 1);   // collision, wb wins
      run_cmd(4'h2, 2'd3, 2'd3, 2'd3, 1'b0, 4'h4, 1'b0, 1'b0, 0, 0);   // src==dst, 2+2
      run_cmd(4'h8, 2'd0, 2'd0, 2'd1, 1'b1, 4'h4, 1'b0, 1'b0, 0, 0);   // 0010<<1, flagin 1
      check_regs("pre_abort_regs");

      run_cmd(4'h2, 2'd0, 2'd1, 2'd2, 1'b0, 4'h0, 1'b0, 1'b0, 0, 2);   // reset in CAPTURE
      host_write(2'd0, 4'h3);
      host_write(2'd1, 4'h4);
      run_cmd(4'h2, 2'd0, 2'd1, 2'd2, 1'b0, 4'h7, 1'b0, 1'b0, 0, 0);   // 3+4
      check_regs("final_regs");
      check("sb_drained", sb.size(), 0);

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
